mem_arbiter: RTL and testbench

- Shares the single memory port (BIOS/EWRAM/IWRAM/VRAM/palette/IO/cart decode behind it) between two requesters: the CPU and the DMA engine.
- Uses fixed priority DMA > CPU. The CPU is never starved: a run counter limits consecutive DMA transfers, and an optional DMA lock holds the bus across a burst.
- Sits between cpu/dma and the memory block. Top level converts the separate rdata/wdata buses to the memory's bidirectional data bus.

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter_port_mux.sv | 43 ++++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the CPU/DMA memory-port arbiter.
package mem_arbiter_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CPU  = 2'd1;
    localparam logic [1:0] S_DMA  = 2'd2;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    localparam int MAX_DMA_RUN_DEF = 16;

endpackage

// File: rtl/mem_arbiter_port_mux.sv
// Combinational selection of the memory-port request fields by current owner.
module mem_port_mux (
    input  logic        i_sel_cpu,
    input  logic        i_sel_dma,
    input  logic        i_cpu_req,
    input  logic [31:0] i_cpu_addr,
    input  logic [1:0]  i_cpu_width,
    input  logic        i_cpu_we,
    input  logic [31:0] i_cpu_wdata,
    input  logic        i_dma_req,
    input  logic [31:0] i_dma_addr,
    input  logic [1:0]  i_dma_width,
    input  logic        i_dma_we,
    input  logic [31:0] i_dma_wdata,
    output logic [31:0] o_mem_addr,
    output logic [1:0]  o_mem_width,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [31:0] o_mem_wdata
);

    always_comb begin
        o_mem_addr  = 32'd0;
        o_mem_width = 2'd0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_mem_wdata = 32'd0;
        if (i_sel_cpu) begin
            o_mem_addr  = i_cpu_addr;
            o_mem_width = i_cpu_width;
            o_mem_read  = i_cpu_req & ~i_cpu_we;
            o_mem_write = i_cpu_req &  i_cpu_we;
            o_mem_wdata = i_cpu_wdata;
        end else if (i_sel_dma) begin
            o_mem_addr  = i_dma_addr;
            o_mem_width = i_dma_width;
            o_mem_read  = i_dma_req & ~i_dma_we;
            o_mem_write = i_dma_req &  i_dma_we;
            o_mem_wdata = i_dma_wdata;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority (DMA > CPU) arbiter for the shared memory port, with a
// DMA run limit that guarantees the CPU a slot and an optional burst lock.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_DMA_RUN = MAX_DMA_RUN_DEF,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [1:0]  cpu_width,
    input  logic        cpu_we,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [1:0]  dma_width,
    input  logic        dma_we,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ready,
    input  logic        dma_lock,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_width,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ok,
    output logic        grant_dma
);

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_DMA_RUN);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_run_cnt;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_sel_cpu;
    logic             w_sel_dma;
    logic             w_cpu_xfer;
    logic             w_dma_xfer;
    logic [CNT_W:0]   w_cnt_inc;
    logic             w_cnt_hit;
    logic             w_cnt_lt_max;

    assign w_sel_cpu    = (r_state == S_CPU);
    assign w_sel_dma    = (r_state == S_DMA);
    assign w_cpu_xfer   = w_sel_cpu & cpu_req & mem_ok;
    assign w_dma_xfer   = w_sel_dma & dma_req & mem_ok;
    assign w_cnt_inc    = {1'b0, r_run_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_cnt_hit    = (w_cnt_inc >= {1'b0, LP_MAX});
    assign w_cnt_lt_max = (r_run_cnt < LP_MAX);

    assign cpu_ready = w_cpu_xfer;
    assign dma_ready = w_dma_xfer;
    assign cpu_rdata = w_sel_cpu ? mem_rdata : 32'd0;
    assign dma_rdata = w_sel_dma ? mem_rdata : 32'd0;
    assign grant_dma = w_sel_dma;

    mem_port_mux u_mux (
        .i_sel_cpu   (w_sel_cpu),
        .i_sel_dma   (w_sel_dma),
        .i_cpu_req   (cpu_req),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_width (cpu_width),
        .i_cpu_we    (cpu_we),
        .i_cpu_wdata (cpu_wdata),
        .i_dma_req   (dma_req),
        .i_dma_addr  (dma_addr),
        .i_dma_width (dma_width),
        .i_dma_we    (dma_we),
        .i_dma_wdata (dma_wdata),
        .o_mem_addr  (mem_addr),
        .o_mem_width (mem_width),
        .o_mem_read  (mem_read),
        .o_mem_write (mem_write),
        .o_mem_wdata (mem_wdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_run_cnt;
        case (r_state)
            S_IDLE: begin
                if (dma_req && (!cpu_req || w_cnt_lt_max))
                    w_state_nxt = S_DMA;
                else if (cpu_req)
                    w_state_nxt = S_CPU;
            end
            S_CPU: begin
                if (w_cpu_xfer) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (!cpu_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DMA: begin
                if (w_dma_xfer) begin
                    w_cnt_nxt = w_cnt_hit ? LP_MAX : w_cnt_inc[CNT_W-1:0];
                    // A waiting CPU breaks the lock once the run limit is reached.
                    if (!(dma_lock && !(cpu_req && w_cnt_hit)))
                        w_state_nxt = S_IDLE;
                end else if (!dma_req && !dma_lock) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_run_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a run limit of 4.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock, mem_ok;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic [1:0]  cpu_width, dma_width;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic        cpu_ready, dma_ready, mem_read, mem_write, grant_dma;
    logic [1:0]  mem_width;

    int n_chk = 0;
    int n_err = 0;
    int cpu_xfers = 0;
    int dma_xfers = 0;

    mem_arbiter #(.MAX_DMA_RUN(4), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_width(cpu_width),
        .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_width(dma_width),
        .dma_we(dma_we), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
        .dma_ready(dma_ready), .dma_lock(dma_lock),
        .mem_addr(mem_addr), .mem_width(mem_width), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ok(mem_ok), .grant_dma(grant_dma)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cpu_req && cpu_ready) cpu_xfers++;
        if (dma_req && dma_ready) dma_xfers++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dx0, cx0;
        rst_n = 1'b0; mem_ok = 1'b1; mem_rdata = 32'h0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0300_0010; cpu_width = 2'd2; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_width = 2'd2; dma_wdata = 32'h0; dma_lock = 1'b0;
        #12;
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_grant_dma", grant_dma, 0);
        cpu_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        nxt;

        // CPU-only read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0300_0010; mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("t1_idle_read", mem_read, 0);
        nxt;
        check("t1_mem_read", mem_read, 1);
        check("t1_mem_addr", mem_addr, 32'h0300_0010);
        check("t1_cpu_ready", cpu_ready, 1);
        check("t1_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        nxt;
        cpu_req = 1'b0; #1;
        check("t1_state_idle", dut.r_state, 0);
        check("t1_cpu_ready_off", cpu_ready, 0);
        check("t1_xfers", cpu_xfers, 1);

        // Simultaneous requests: DMA first
        cpu_req = 1'b1; cpu_addr = 32'h0300_0020;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0200_0000; dma_wdata = 32'h1122_3344;
        nxt;
        check("t2_grant_dma", grant_dma, 1);
        check("t2_mem_write", mem_write, 1);
        check("t2_mem_wdata", mem_wdata, 32'h1122_3344);
        check("t2_mem_addr", mem_addr, 32'h0200_0000);
        check("t2_dma_ready", dma_ready, 1);
        check("t2_cpu_wait", cpu_ready, 0);
        nxt;
        dma_req = 1'b0; #1;
        check("t2_idle_grant", grant_dma, 0);
        check("t2_idle_strobe", {mem_read, mem_write}, 0);
        nxt;
        check("t2_cpu_ready", cpu_ready, 1);
        check("t2_cpu_addr", mem_addr, 32'h0300_0020);
        check("t2_dma_before_cpu", dma_xfers, 1);
        check("t2_cpu_before", cpu_xfers, 1);
        nxt;
        cpu_req = 1'b0; #1;
        check("t2_cpu_after", cpu_xfers, 2);

        // Locked burst against a waiting CPU
        dx0 = dma_xfers;
        cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nxt;
            check("t3_burst_grant", grant_dma, 1);
            check("t3_burst_ready", dma_ready, 1);
        end
        nxt;
        check("t3_idle_grant", grant_dma, 0);
        check("t3_run_cnt_sat", dut.r_run_cnt, 4);
        check("t3_dma_count", dma_xfers - dx0, 4);
        nxt;
        check("t3_cpu_ready", cpu_ready, 1);
        check("t3_cpu_grant", grant_dma, 0);
        nxt;
        cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0; #1;
        check("t3_run_cnt_clr", dut.r_run_cnt, 0);
        check("t3_cpu_xfers", cpu_xfers, 3);

        // Unaligned byte write with one stall cycle
        cx0 = cpu_xfers;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_width = 2'd0; cpu_addr = 32'h0300_0001; cpu_wdata = 32'h0000_00AB;
        nxt;
        mem_ok = 1'b0; #1;
        check("t4_stall_write", mem_write, 1);
        check("t4_stall_ready", cpu_ready, 0);
        nxt;
        mem_ok = 1'b1; #1;
        check("t4_write_held", mem_write, 1);
        check("t4_width", mem_width, 0);
        check("t4_ready", cpu_ready, 1);
        nxt;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_width = 2'd2; #1;
        check("t4_write_off", mem_write, 0);
        check("t4_one_xfer", cpu_xfers - cx0, 1);

        // Asynchronous reset during a DMA write
        dx0 = dma_xfers;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0200_0010; dma_wdata = 32'h55;
        nxt;
        mem_ok = 1'b0; #1;
        check("t5_dma_write", mem_write, 1);
        cpu_req = 1'b1; cpu_addr = 32'h0300_0030;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_write", mem_write, 0);
        check("t5_rst_grant", grant_dma, 0);
        check("t5_rst_dma_ready", dma_ready, 0);
        check("t5_rst_state", dut.r_state, 0);
        nxt;
        rst_n = 1'b1; dma_req = 1'b0; dma_we = 1'b0; mem_ok = 1'b1; #1;
        check("t5_no_dma_xfer", dma_xfers - dx0, 0);
        check("t5_post_idle", mem_read, 0);
        nxt;
        check("t5_cpu_grant", mem_read, 1);
        check("t5_cpu_ready", cpu_ready, 1);
        nxt;
        cpu_req = 1'b0; #1;

        // Lock held across a request gap
        dx0 = dma_xfers; cx0 = cpu_xfers;
        dma_req = 1'b1; dma_lock = 1'b1;
        nxt;
        check("t6_first_ready", dma_ready, 1);
        nxt;
        dma_req = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) cpu_req = 1'b1;
            #1;
            check("t6_gap_grant", grant_dma, 1);
            check("t6_gap_strobes", {mem_read, mem_write}, 0);
            check("t6_gap_cpu", cpu_ready, 0);
            nxt;
        end
        dma_req = 1'b1; #1;
        check("t6_resume_ready", dma_ready, 1);
        nxt;
        dma_req = 1'b0; dma_lock = 1'b0; #1;
        check("t6_unlock_grant", grant_dma, 1);
        check("t6_cpu_blocked", cpu_xfers - cx0, 0);
        nxt;
        check("t6_idle_grant", grant_dma, 0);
        nxt;
        check("t6_cpu_ready", cpu_ready, 1);
        nxt;
        cpu_req = 1'b0; #1;
        check("t6_dma_count", dma_xfers - dx0, 2);
        check("t6_cpu_count", cpu_xfers - cx0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
